// File: rtl/fb_dma_pkg.sv
// fb_dma_pkg: shared FSM state type and counter width helper for fb_wr_dma
package fb_dma_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fb_wr_dma_if.sv
// fb_wr_dma_if: coprocessor stream in, framebuffer write port and status out; FB_WR_DMA_VFLIP_EN adds vflip
interface fb_wr_dma_if #(parameter int IDX_W = 1, parameter int ADDR_W = 17, parameter int PIX_W = 8) ();
  logic              start;
  logic [IDX_W-1:0]  img_idx;
  logic              we_in;
  logic [PIX_W-1:0]  pix_in;
`ifdef FB_WR_DMA_VFLIP_EN
  logic              vflip;
`endif
  logic              we_out;
  logic [ADDR_W-1:0] waddr;
  logic [PIX_W-1:0]  wdata;
  logic              busy;
  logic              done;
  logic              ovf;
  logic              idx_err;
  modport master (
`ifdef FB_WR_DMA_VFLIP_EN
    output vflip,
`endif
    output start, img_idx, we_in, pix_in,
    input  we_out, waddr, wdata, busy, done, ovf, idx_err
  );
  modport slave (
`ifdef FB_WR_DMA_VFLIP_EN
    input  vflip,
`endif
    input  start, img_idx, we_in, pix_in,
    output we_out, waddr, wdata, busy, done, ovf, idx_err
  );
endinterface

// File: rtl/fb_dma_addr_gen.sv
// fb_dma_addr_gen: x/y pixel counters and row base giving the write address and last-pixel flag
module fb_dma_addr_gen
  import fb_dma_pkg::*;
#(
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int FB_STRIDE = 512,
  parameter int NUM_SLOTS = 2,
  parameter int ADDR_W    = 17,
  parameter int IDX_W     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              acc,
  input  logic              flip,
  input  logic [IDX_W-1:0]  slot,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam int XW = cnt_w(IMG_W);
  localparam int YW = cnt_w(IMG_H);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(FB_STRIDE);
  localparam logic [ADDR_W-1:0] FLIP_OFS = ADDR_W'((IMG_H - 1) * FB_STRIDE);
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d, base;
  logic flip_q, flip_d, x_end, adv, row_adv;
  assign x_end   = x_q == X_MAX;
  assign last    = x_end && y_q == Y_MAX;
  assign adv     = acc && !last;
  assign row_adv = adv && x_end;
  assign addr    = row_base_q + ADDR_W'(x_q);
  always_comb begin
    base = '0;
    for (int i = 0; i < NUM_SLOTS; i++) if (slot == IDX_W'(i)) base = ADDR_W'(i * IMG_W);
    x_d        = start ? '0 : adv ? (x_end ? '0 : x_q + 1'b1) : x_q;
    y_d        = start ? '0 : row_adv ? y_q + 1'b1 : y_q;
    flip_d     = start ? flip : flip_q;
    row_base_d = start ? base + (flip ? FLIP_OFS : '0)
               : row_adv ? (flip_q ? row_base_q - STRIDE : row_base_q + STRIDE) : row_base_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      flip_q     <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      flip_q     <= flip_d;
    end
  end
endmodule

// File: rtl/fb_wr_dma.sv
// fb_wr_dma: tile-placing framebuffer write DMA with status flags; FB_WR_DMA_VFLIP_EN enables vertical flip
module fb_wr_dma
  import fb_dma_pkg::*;
#(
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int FB_STRIDE = 512,
  parameter int NUM_SLOTS = 2,
  parameter int ADDR_W    = 17,
  parameter int PIX_W     = 8
) (
  input logic       clk,
  input logic       rst_n,
  fb_wr_dma_if.slave bus
);
  localparam int IDX_W = cnt_w(NUM_SLOTS);
  if (NUM_SLOTS * IMG_W > FB_STRIDE) begin : g_slot_chk
    $error("fb_wr_dma: NUM_SLOTS*IMG_W exceeds FB_STRIDE");
  end
  if (FB_STRIDE * IMG_H > (1 << ADDR_W)) begin : g_addr_chk
    $error("fb_wr_dma: FB_STRIDE*IMG_H exceeds address space");
  end
  state_t state_q, state_d;
  logic we_out_q, we_out_d, done_q, done_d, ovf_q, ovf_d, idx_err_q, idx_err_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, addr;
  logic [PIX_W-1:0] wdata_q, wdata_d;
  logic run, acc, idx_ok, flip, last;
  logic [IDX_W-1:0] slot;
`ifdef FB_WR_DMA_VFLIP_EN
  assign flip = bus.vflip;
`else
  assign flip = 1'b0;
`endif
  assign run    = state_q == RUN;
  assign acc    = run && bus.we_in && !bus.start;
  assign idx_ok = {1'b0, bus.img_idx} < (IDX_W + 1)'(NUM_SLOTS);
  assign slot   = idx_ok ? bus.img_idx : '0;
  fb_dma_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .FB_STRIDE(FB_STRIDE),
    .NUM_SLOTS(NUM_SLOTS), .ADDR_W(ADDR_W), .IDX_W(IDX_W)
  ) u_addr_gen (
    .clk(clk), .rst_n(rst_n), .start(bus.start), .acc(acc), .flip(flip),
    .slot(slot), .addr(addr), .last(last)
  );
  always_comb begin
    state_d   = bus.start ? RUN : (acc && last) ? IDLE : state_q;
    we_out_d  = acc;
    waddr_d   = acc ? addr : waddr_q;
    wdata_d   = acc ? bus.pix_in : wdata_q;
    done_d    = acc && last;
    ovf_d     = bus.start ? 1'b0 : (bus.we_in && !run) ? 1'b1 : ovf_q;
    idx_err_d = bus.start ? !idx_ok : idx_err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_out_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      idx_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_out_q  <= we_out_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      idx_err_q <= idx_err_d;
    end
  end
  assign bus.we_out  = we_out_q;
  assign bus.waddr   = waddr_q;
  assign bus.wdata   = wdata_q;
  assign bus.busy    = run;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.idx_err = idx_err_q;
endmodule

// File: tb/tb_fb_wr_dma.sv
// tb_fb_wr_dma: scoreboard bench for fb_wr_dma on a small 16x8 image, 3 slots, stride 56
module tb_fb_wr_dma;
  localparam int W = 16, H = 8, S = 56, NS = 3, AW = 9, PW = 8, IW = 2;
  typedef struct {logic [AW-1:0] a; logic [PW-1:0] d; logic dn;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, bad = 0, ndone = 0, slot = 0, cnt = 0, frames = 0;
  logic flip = 1'b0;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  fb_wr_dma_if #(.IDX_W(IW), .ADDR_W(AW), .PIX_W(PW)) bus ();
  fb_wr_dma #(.IMG_W(W), .IMG_H(H), .FB_STRIDE(S), .NUM_SLOTS(NS), .ADDR_W(AW), .PIX_W(PW))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_pix(input logic [PW-1:0] p);
    exp_t e;
    int row;
    row = flip ? H - 1 - cnt / W : cnt / W;
    e.a = AW'(slot * W + row * S + cnt % W);
    e.d = p;
    e.dn = cnt == W * H - 1;
    exp_q.push_back(e);
    cnt++;
  endtask
  task automatic feed(input int n, input bit gap);
    logic [PW-1:0] p;
    for (int i = 0; i < n; i++) begin
      p = PW'(cnt * 13 + slot * 5 + 1);
      bus.we_in = 1'b1;
      bus.pix_in = p;
      push_pix(p);
      tick();
      if (gap) begin
        bus.we_in = 1'b0;
        bus.pix_in = 8'h5a;
        tick();
      end
    end
    bus.we_in = 1'b0;
  endtask
  task automatic do_start(input int idx, input bit we);
    bus.start = 1'b1;
    bus.img_idx = IW'(idx);
    bus.we_in = we;
    bus.pix_in = 8'haa;
`ifdef FB_WR_DMA_VFLIP_EN
    bus.vflip = flip;
`endif
    tick();
    bus.start = 1'b0;
    bus.we_in = 1'b0;
    slot = idx < NS ? idx : 0;
    cnt = 0;
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done && !bus.we_out) chk("done_without_write", bus.done, 0);
      if (bus.done && bus.we_out) ndone++;
      if (bus.we_out) begin
        if (exp_q.size() == 0) chk("unexpected_write", bus.waddr, 32'hffffffff);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("waddr", bus.waddr, e.a);
          chk("wdata", bus.wdata, e.d);
          chk("done_flag", bus.done, e.dn);
        end
      end
    end
  end
  initial begin
    bus.start = 1'b0;
    bus.img_idx = '0;
    bus.we_in = 1'b0;
    bus.pix_in = '0;
`ifdef FB_WR_DMA_VFLIP_EN
    bus.vflip = 1'b0;
`endif
    tick();
    tick();
    chk("rst_we_out", bus.we_out, 0);
    chk("rst_waddr", bus.waddr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_idx_err", bus.idx_err, 0);
    rst_n = 1'b1;
    tick();
    do_start(0, 0);
    chk("t1_busy", bus.busy, 1);
    feed(W * H, 0);
    frames++;
    chk("t1_last_addr", bus.waddr, (H - 1) * S + W - 1);
    chk("t1_done", bus.done, 1);
    chk("t1_busy_low", bus.busy, 0);
    tick();
    chk("t1_done_pulse", bus.done, 0);
    bus.we_in = 1'b1;
    repeat (3) tick();
    bus.we_in = 1'b0;
    chk("t3_ovf", bus.ovf, 1);
    chk("t3_no_write", bus.we_out, 0);
    do_start(1, 0);
    chk("t3_ovf_clear", bus.ovf, 0);
    feed(W * H, 1);
    frames++;
    chk("t2_busy_low", bus.busy, 0);
    chk("t2_last_addr", bus.waddr, (H - 1) * S + 2 * W - 1);
    do_start(0, 0);
    feed(20, 0);
    do_start(1, 1);
    chk("t4_busy", bus.busy, 1);
    feed(W * H, 0);
    frames++;
    do_start(3, 0);
    chk("t5_idx_err", bus.idx_err, 1);
    feed(3, 0);
    do_start(2, 0);
    chk("t5_idx_err_clear", bus.idx_err, 0);
    feed(5, 0);
    tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we_out", bus.we_out, 0);
    chk("mid_rst_waddr", bus.waddr, 0);
    chk("mid_rst_wdata", bus.wdata, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_idx_err", bus.idx_err, 0);
    tick();
    rst_n = 1'b1;
    bus.we_in = 1'b1;
    tick();
    bus.we_in = 1'b0;
    chk("post_rst_idle_ovf", bus.ovf, 1);
    chk("post_rst_no_write", bus.we_out, 0);
`ifdef FB_WR_DMA_VFLIP_EN
    flip = 1'b1;
    do_start(0, 0);
    feed(W * H, 0);
    frames++;
    chk("flip_last_addr", bus.waddr, W - 1);
    chk("flip_done", bus.done, 1);
    flip = 1'b0;
`endif
    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    chk("done_count", ndone, frames);
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end
endmodule
